// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain writer: serialises parallel bitstream words onto ccff_head
// LSB first and returns the displaced chain contents from ccff_tail as readback words.
module ccff_bitstream_loader #(
  parameter int DATA_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = $clog2(CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int WB_W  = $clog2(DATA_W+1);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   word_bits_q, word_bits_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              rb_valid_q, rb_valid_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;

  logic [31:0]       rem;
  logic              last_bit;
  logic              chain_end;

  assign last_bit  = (word_bits_q == WB_W'(1));
  assign chain_end = ((32'(bit_cnt_q) + 32'd1) == 32'(CHAIN_LEN));

  // FSM: state register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)   state_d = S_FETCH;
      S_FETCH: if (s_valid) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = chain_end ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs decoded from state so reset forces them low immediately
  always_comb begin
    s_ready   = (state_q == S_FETCH);
    shift_en  = (state_q == S_SHIFT);
    ccff_head = (state_q == S_SHIFT) & tx_sr_q[0];
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    word_bits_d = word_bits_q;
    idx_d       = idx_q;
    done_d      = done_q;
    rb_valid_d  = 1'b0;
    rb_data_d   = rb_data_q;
    rem         = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      S_FETCH: begin
        if (s_valid) begin
          tx_sr_d     = s_data;
          // cleared so the unfilled top of a final partial word reads back as 0
          rx_sr_d     = '0;
          idx_d       = '0;
          word_bits_d = (rem < 32'(DATA_W)) ? WB_W'(rem) : WB_W'(DATA_W);
        end
      end
      S_SHIFT: begin
        tx_sr_d          = tx_sr_q >> 1;
        rx_sr_d[idx_q]   = ccff_tail;
        bit_cnt_d        = bit_cnt_q + 1'b1;
        word_bits_d      = word_bits_q - 1'b1;
        idx_d            = idx_q + 1'b1;
        if (last_bit) begin
          rb_valid_d = 1'b1;
          rb_data_d  = rx_sr_d;
          if (chain_end) done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      word_bits_q <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      rb_valid_q  <= 1'b0;
      rb_data_q   <= '0;
    end else begin
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      word_bits_q <= word_bits_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      rb_valid_q  <= rb_valid_d;
      rb_data_q   <= rb_data_d;
    end
  end

  assign done     = done_q;
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 20-stage chain model on the serial side, expected
// head stream and readback derived from the words and a snapshot of the chain.
module tb_ccff_bitstream_loader;

  logic       prog_clk = 1'b0;
  logic       pReset, start, s_valid, ccff_tail;
  logic [7:0] s_data, rb_data;
  logic       s_ready, ccff_head, shift_en, rb_valid, busy, done;

  logic [19:0] chain;
  logic [19:0] got_head;
  int          nshift, run;
  bit          prev_ready;
  logic        head_q[$];
  logic [7:0]  rb_q[$];
  int          burst_q[$];
  bit          pre_q[$];
  logic [7:0]  words[3];
  int          stalls[3];
  int          n_assert = 0;
  int          n_fail = 0;

  ccff_bitstream_loader #(.DATA_W(8), .CHAIN_LEN(20)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .ccff_head(ccff_head), .shift_en(shift_en), .ccff_tail(ccff_tail),
    .rb_data(rb_data), .rb_valid(rb_valid), .busy(busy), .done(done)
  );

  always #5 prog_clk = ~prog_clk;

  // fabric chain: stage 0 fed by head, tail is the last stage
  always @(posedge prog_clk) begin
    if (shift_en) begin
      chain  <= {chain[18:0], ccff_head};
      nshift <= nshift + 1;
    end
  end
  assign ccff_tail = chain[19];

  always @(negedge prog_clk) begin
    if (shift_en) begin
      head_q.push_back(ccff_head);
      if (run == 0) pre_q.push_back(prev_ready);
      run++;
    end else if (run > 0) begin
      burst_q.push_back(run);
      run = 0;
    end
    if (rb_valid) rb_q.push_back(rb_data);
    prev_ready = s_ready;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input int stall, input int k);
    int cnt = 0;
    while (!s_ready && cnt < 100) begin tick(); cnt++; end
    check($sformatf("fetch_ready_%0d", k), 32'(s_ready), 1);
    for (int i = 0; i < stall; i++) begin
      check($sformatf("stall_w%0d_c%0d", k, i), {29'd0, s_ready, shift_en, ccff_head}, 32'b100);
      tick();
    end
    s_valid = 1'b1;
    s_data  = w;
    tick();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic do_load(input string nm, input bit pre_done, input bit pulse_start);
    logic [19:0] snap, exp_bits, exp_chain;
    logic [7:0]  exp_rb[3];
    int          n0, cnt;
    snap = chain;
    head_q.delete(); rb_q.delete(); burst_q.delete(); pre_q.delete();
    run = 0;
    n0  = nshift;
    for (int i = 0; i < 20; i++) begin
      exp_bits[i]       = words[i/8][i%8];
      exp_chain[19 - i] = exp_bits[i];
    end
    for (int k = 0; k < 3; k++) begin
      exp_rb[k] = 8'h00;
      for (int j = 0; j < 8; j++)
        if (8*k + j < 20) exp_rb[k][j] = snap[19 - (8*k + j)];
    end
    check({nm, "_pre_done"}, 32'(done), 32'(pre_done));
    start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, "_done_clr"}, 32'(done), 0);
    check({nm, "_busy"}, 32'(busy), 1);
    for (int k = 0; k < 3; k++) begin
      send_word(words[k], stalls[k], k);
      if (pulse_start && k == 0) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    cnt = 0;
    while (busy && cnt < 100) begin tick(); cnt++; end
    check({nm, "_finish"}, 32'(busy), 0);
    tick();
    check({nm, "_nshift"}, 32'(nshift - n0), 20);
    got_head = '0;
    for (int i = 0; i < head_q.size() && i < 20; i++) got_head[i] = head_q[i];
    check({nm, "_head_n"}, 32'(head_q.size()), 20);
    check({nm, "_head"}, 32'(got_head), 32'(exp_bits));
    check({nm, "_bursts"}, 32'(burst_q.size()), 3);
    if (burst_q.size() == 3)
      check({nm, "_burst_len"}, {8'd0, 8'(burst_q[0]), 8'(burst_q[1]), 8'(burst_q[2])}, 32'h00080804);
    check({nm, "_fetch_before"}, 32'(pre_q.size() == 3 && pre_q[0] && pre_q[1] && pre_q[2]), 1);
    check({nm, "_rb_n"}, 32'(rb_q.size()), 3);
    for (int k = 0; k < 3 && k < rb_q.size(); k++)
      check($sformatf("%s_rb%0d", nm, k), 32'(rb_q[k]), 32'(exp_rb[k]));
    check({nm, "_chain"}, 32'(chain), 32'(exp_chain));
    check({nm, "_done"}, 32'(done), 1);
  endtask

  initial begin
    logic [19:0] pre;
    int          cnt;
    pReset = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    chain = '0; nshift = 0; run = 0;

    // asynchronous reset taking effect between clock edges
    #2 pReset = 1'b1;
    #1;
    check("rst_outs", {26'd0, s_ready, ccff_head, shift_en, rb_valid, busy, done}, 0);
    check("rst_rb_data", 32'(rb_data), 0);
    tick(); tick();
    pReset = 1'b0;
    tick(); tick();
    check("idle_outs", {26'd0, s_ready, ccff_head, shift_en, rb_valid, busy, done}, 0);

    // basic load over a preloaded chain (5A, C3, 9 in shift-out order)
    pre = 20'h9C35A;
    for (int i = 0; i < 20; i++) chain[19 - i] = pre[i];
    words = '{8'hA5, 8'h3C, 8'hFF};
    stalls = '{0, 0, 0};
    do_load("basic", 1'b0, 1'b0);
    check("basic_head_lit", 32'(got_head), 32'h000F3CA5);
    if (rb_q.size() == 3)
      check("basic_rb_lit", {8'd0, rb_q[0], rb_q[1], rb_q[2]}, 32'h005AC309);

    // same data with a 5-cycle stall before word 2, also returns load-2 contents
    stalls = '{0, 5, 0};
    do_load("stall", 1'b1, 1'b0);
    check("stall_head_lit", 32'(got_head), 32'h000F3CA5);
    if (rb_q.size() == 3)
      check("stall_rb_lit", {8'd0, rb_q[0], rb_q[1], rb_q[2]}, 32'h00A53C0F);

    // start pulsed during SHIFT is ignored
    words = '{8'($urandom), 8'($urandom), 8'($urandom)};
    stalls = '{0, 0, 0};
    do_load("start_in_shift", 1'b1, 1'b1);

    // reset after 11 shifts
    cnt = nshift;
    start = 1'b1; tick(); start = 1'b0;
    send_word(8'($urandom), 0, 0);
    send_word(8'($urandom), 0, 1);
    for (int i = 0; i < 50 && (nshift - cnt) < 11; i++) tick();
    check("abort_shifts", 32'(nshift - cnt), 11);
    check("abort_in_shift", 32'(shift_en), 1);
    #3 pReset = 1'b1;
    #1;
    check("abort_outs", {26'd0, s_ready, ccff_head, shift_en, rb_valid, busy, done}, 0);
    check("abort_rb_data", 32'(rb_data), 0);
    tick();
    pReset = 1'b0;
    tick();
    words = '{8'($urandom), 8'($urandom), 8'($urandom)};
    do_load("after_abort", 1'b0, 1'b0);

    // randomized loads with random stalls
    for (int r = 0; r < 4; r++) begin
      words = '{8'($urandom), 8'($urandom), 8'($urandom)};
      stalls = '{$urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)};
      do_load($sformatf("rand%0d", r), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
